gcd_controller: RTL and testbench

GCD_CONTROLLER -- requirements
Module: gcd_controller

---
 rtl/gcd_controller.sv | 119 +++++++++++
 tb/tb_gcd_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// Control FSM for a subtract-and-compare GCD datapath (registers A/B, one subtractor).
// Moore machine: every output is decoded from the registered state and iteration counter.
module gcd_controller #(
  parameter int unsigned      CNT_W    = 16,
  parameter logic [CNT_W-1:0] MAX_ITER = CNT_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_SUB_A,
    S_SUB_B,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  // NOTE: async reset clears only the state and counter; outputs follow
  // combinationally, so they drop to zero the moment rst_n falls.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          iter_d  = '0;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_CMP;
      S_CMP: begin
        // Equality wins over the limit so a result found on the last allowed
        // subtraction is still reported as valid; no flag at all is an abort.
        if (eq)                      state_d = S_DONE;
        else if (iter_q == MAX_ITER) state_d = S_ERR;
        else if (gt)                 state_d = S_SUB_A;
        else if (lt)                 state_d = S_SUB_B;
        else                         state_d = S_ERR;
      end
      S_SUB_A, S_SUB_B: begin
        state_d = S_CMP;
        if (iter_q != '1) iter_d = iter_q + CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    sel_in = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    busy   = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD_A: begin
        ldA    = 1'b1;
        sel_in = 1'b1;
      end
      S_LOAD_B: begin
        ldB    = 1'b1;
        sel_in = 1'b1;
      end
      S_SUB_A: begin
        ldA  = 1'b1;
        sel2 = 1'b1;
      end
      S_SUB_B: begin
        ldB  = 1'b1;
        sel1 = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller: a small A/B datapath closes the loop and
// each run is checked against hand-derived state sequences, latencies and results.
module tb_gcd_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        gt, lt, eq;
  logic        ldA, ldB, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] iter_cnt;

  logic [7:0]  a_r = 8'd0;
  logic [7:0]  b_r = 8'd0;
  logic [7:0]  op_a = 8'd0;
  logic [7:0]  op_b = 8'd0;
  logic        force_bad = 1'b0;
  logic [7:0]  m1, m2, bus, data_in;

  int checks = 0;
  int errors = 0;

  logic [31:0] seq;
  int          lat;
  logic [3:0]  c;
  bit          found;

  gcd_controller #(.CNT_W(16), .MAX_ITER(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gt(gt), .lt(lt), .eq(eq),
    .ldA(ldA), .ldB(ldB), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  assign data_in = ldA ? op_a : op_b;
  assign m1      = sel1 ? b_r : a_r;
  assign m2      = sel2 ? b_r : a_r;
  assign bus     = sel_in ? data_in : 8'(m1 - m2);
  assign gt      = !force_bad && (a_r > b_r);
  assign lt      = !force_bad && (a_r < b_r);
  assign eq      = !force_bad && (a_r == b_r);

  always @(posedge clk) begin
    if (ldA) a_r <= bus;
    if (ldB) b_r <= bus;
  end

  // Codes: 0 IDLE, 1 LOAD_A, 2 LOAD_B, 3 CMP, 4 SUB_A, 5 SUB_B, 6 DONE, 7 ERR, F illegal
  function automatic logic [3:0] obs_code();
    case ({busy, ldA, ldB, sel1, sel2, sel_in, done, err})
      8'b0_0000000: return 4'h0;
      8'b1_1000100: return 4'h1;
      8'b1_0100100: return 4'h2;
      8'b1_0000000: return 4'h3;
      8'b1_1001000: return 4'h4;
      8'b1_0110000: return 4'h5;
      8'b1_0000010: return 4'h6;
      8'b1_0000001: return 4'h7;
      default:      return 4'hF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and record the last eight state codes up to DONE/ERR.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                        input bit toggle, output logic [31:0] s, output int l);
    logic [3:0] k;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    s     = '0;
    l     = -1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      k = obs_code();
      s = {s[27:0], k};
      if (k == 4'h6 || k == 4'h7 || k == 4'hF) begin
        l = i;
        break;
      end
      if (toggle) start = ~start;
      step();
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_outputs", 32'(obs_code()), 32'h0);
    check("reset_iter", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'(obs_code()), 32'h0);

    // 12/8 with start toggling while busy
    run_op(8'd12, 8'd8, 1'b0, 1'b1, seq, lat);
    check("seq_12_8", seq, 32'h12343536);
    check("lat_12_8", 32'(lat), 32'd7);
    check("a_12_8", 32'(a_r), 32'd4);
    check("iter_12_8", 32'(iter_cnt), 32'd2);
    step();
    check("idle_after_done", 32'(obs_code()), 32'h0);
    check("iter_hold_done", 32'(iter_cnt), 32'd2);

    // equal operands
    run_op(8'd7, 8'd7, 1'b0, 1'b0, seq, lat);
    check("seq_7_7", seq, 32'h00001236);
    check("lat_7_7", 32'(lat), 32'd3);
    check("iter_7_7", 32'(iter_cnt), 32'd0);
    check("a_7_7", 32'(a_r), 32'd7);
    step();

    // zero operand runs into the iteration limit
    run_op(8'd0, 8'd5, 1'b0, 1'b0, seq, lat);
    check("seq_0_5", seq, 32'h35353537);
    check("lat_0_5", 32'(lat), 32'd11);
    check("iter_0_5", 32'(iter_cnt), 32'd4);
    step();
    check("idle_after_err", 32'(obs_code()), 32'h0);
    check("iter_hold_err", 32'(iter_cnt), 32'd4);

    // asynchronous reset during the second SUB_A of 100/3
    op_a  = 8'd100;
    op_b  = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      c = obs_code();
      if (c == 4'h4 && iter_cnt == 16'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("reach_sub_a", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs_code()), 32'h0);
    check("async_reset_iter", 32'(iter_cnt), 32'd0);
    step();
    check("reset_held", 32'(obs_code()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_release", 32'(obs_code()), 32'h0);
    run_op(8'd9, 8'd6, 1'b0, 1'b0, seq, lat);
    check("seq_9_6", seq, 32'h12343536);
    check("lat_9_6", 32'(lat), 32'd7);
    check("a_9_6", 32'(a_r), 32'd3);
    step();

    // illegal flags in CMP
    force_bad = 1'b1;
    run_op(8'd5, 8'd3, 1'b0, 1'b0, seq, lat);
    force_bad = 1'b0;
    check("seq_bad_flags", seq, 32'h00001237);
    check("lat_bad_flags", 32'(lat), 32'd3);
    step();
    check("idle_after_bad", 32'(obs_code()), 32'h0);
    check("iter_bad_flags", 32'(iter_cnt), 32'd0);

    // start held high: one IDLE cycle then automatic relaunch
    run_op(8'd6, 8'd4, 1'b1, 1'b0, seq, lat);
    check("seq_6_4", seq, 32'h12343536);
    check("lat_6_4", 32'(lat), 32'd7);
    check("a_6_4", 32'(a_r), 32'd2);
    step();
    check("held_idle_gap", 32'(obs_code()), 32'h0);
    step();
    check("held_relaunch", 32'(obs_code()), 32'h1);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_code() == 4'h6) begin
        found = 1'b1;
        break;
      end
    end
    check("relaunch_done", 32'(found), 32'd1);
    check("relaunch_a", 32'(a_r), 32'd2);
    check("relaunch_iter", 32'(iter_cnt), 32'd2);
    step();
    check("final_idle", 32'(obs_code()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
